// File: rtl/i2s_rx_deser_if.sv
// Sample-pair bus between the I2S receiver and the downstream filter/FIFO stage.
// master = receiver (drives samples, status pulses), slave = consumer (drives ready).
`timescale 1ns/1ps
interface i2s_rx_deser_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] sample_l;
   logic [DATA_W-1:0] sample_r;
   logic              sample_valid;
   logic              sample_ready;
   logic              overrun;
   logic              frame_err;

   modport master (
      output sample_l, sample_r, sample_valid, overrun, frame_err,
      input  sample_ready
   );

   modport slave (
      input  sample_l, sample_r, sample_valid, overrun, frame_err,
      output sample_ready
   );
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S receiver: deserialises stereo serial audio into left-justified L/R pairs
// presented on a valid/ready bus. The bit clock arrives as a level in the i2s_clk
// domain and is edge-detected here. Optional saturating overrun counter enabled by
// defining I2S_RX_OVR_CNT_EN (adds the ovr_cnt port).
`timescale 1ns/1ps
module i2s_rx_deser #(
   parameter int DATA_W      = 24,
   parameter int SLOT_MAX    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic            i2s_clk,
   input  logic            reset_n,
   input  logic            sck_in,
   input  logic            ws_in,
   input  logic            sd_in,
   i2s_rx_deser_if.master  bus
`ifdef I2S_RX_OVR_CNT_EN
   ,
   output logic [7:0]      ovr_cnt
`endif
);
   localparam int CNT_W = $clog2(SLOT_MAX + 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_MAX);

   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

   // {sck, ws, sd} delayed together so their relative timing is preserved
   logic [2:0] sync_reg [SYNC_STAGES];
   logic       sck_prev_reg;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [DATA_W-1:0] left_reg, left_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              ws_prev_reg, ws_prev_next;
   logic [DATA_W-1:0] l_reg, l_next;
   logic [DATA_W-1:0] r_reg, r_next;
   logic              valid_reg, valid_next;
   logic              ovr_reg, ovr_next;
   logic              ferr_reg, ferr_next;

   logic              sck_d, ws_d, sd_d, bit_ev;
   logic              pair_done, err_now;
   logic [DATA_W-1:0] word_cur;

   assign sck_d  = sync_reg[SYNC_STAGES-1][2];
   assign ws_d   = sync_reg[SYNC_STAGES-1][1];
   assign sd_d   = sync_reg[SYNC_STAGES-1][0];
   assign bit_ev = sck_d & ~sck_prev_reg;

   // Input delay line and bit-clock edge history
   always_ff @(posedge i2s_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= 3'b000;
         sck_prev_reg <= 1'b0;
      end else begin
         sync_reg[0] <= {sck_in, ws_in, sd_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
         sck_prev_reg <= sck_d;
      end
   end

   // Current slot word with this event's bit placed at its MSB-first position;
   // bits beyond DATA_W fall outside the loop and are ignored, short slots stay zero-padded
   always_comb begin
      word_cur = shift_reg;
      for (int i = 0; i < DATA_W; i++) begin
         if (int'(cnt_reg) == DATA_W - 1 - i) word_cur[i] = sd_d;
      end
   end

   // Framing FSM: next state, word assembly and completion/error strobes
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      left_next    = left_reg;
      cnt_next     = cnt_reg;
      ws_prev_next = ws_prev_reg;
      pair_done    = 1'b0;
      err_now      = 1'b0;
      if (bit_ev) begin
         ws_prev_next = ws_d;
         case (state_reg)
            SYNC: begin
               if (ws_prev_reg && !ws_d) begin
                  state_next = LEFT;
                  cnt_next   = '0;
                  shift_next = '0;
               end
            end
            LEFT, RIGHT: begin
               if (ws_d != ws_prev_reg) begin
                  // this bit is the LSB of the word on channel ws_prev
                  cnt_next   = '0;
                  shift_next = '0;
                  if (state_reg == LEFT) begin
                     left_next  = word_cur;
                     state_next = RIGHT;
                  end else begin
                     pair_done  = 1'b1;
                     state_next = LEFT;
                  end
               end else if (cnt_reg == SLOT_LAST) begin
                  err_now    = 1'b1;
                  state_next = SYNC;
                  cnt_next   = '0;
                  shift_next = '0;
               end else begin
                  cnt_next   = cnt_reg + CNT_W'(1);
                  shift_next = word_cur;
               end
            end
            default: state_next = SYNC;
         endcase
      end
   end

   // Output stage: load on completion when free or being accepted, otherwise drop
   always_comb begin
      l_next     = l_reg;
      r_next     = r_reg;
      valid_next = valid_reg & ~bus.sample_ready;
      ovr_next   = 1'b0;
      ferr_next  = err_now;
      if (pair_done) begin
         if (!valid_reg || bus.sample_ready) begin
            l_next     = left_reg;
            r_next     = word_cur;
            valid_next = 1'b1;
         end else begin
            ovr_next = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge i2s_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= SYNC;
         shift_reg   <= '0;
         left_reg    <= '0;
         cnt_reg     <= '0;
         ws_prev_reg <= 1'b0;
         l_reg       <= '0;
         r_reg       <= '0;
         valid_reg   <= 1'b0;
         ovr_reg     <= 1'b0;
         ferr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         left_reg    <= left_next;
         cnt_reg     <= cnt_next;
         ws_prev_reg <= ws_prev_next;
         l_reg       <= l_next;
         r_reg       <= r_next;
         valid_reg   <= valid_next;
         ovr_reg     <= ovr_next;
         ferr_reg    <= ferr_next;
      end
   end

   assign bus.sample_l     = l_reg;
   assign bus.sample_r     = r_reg;
   assign bus.sample_valid = valid_reg;
   assign bus.overrun      = ovr_reg;
   assign bus.frame_err    = ferr_reg;

`ifdef I2S_RX_OVR_CNT_EN
   logic [7:0] ovr_cnt_reg;

   // Saturating count of dropped pairs, advanced with each overrun pulse
   always_ff @(posedge i2s_clk or negedge reset_n) begin
      if (!reset_n) begin
         ovr_cnt_reg <= 8'd0;
      end else if (ovr_next && ovr_cnt_reg != 8'hFF) begin
         ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
      end
   end

   assign ovr_cnt = ovr_cnt_reg;
`endif
endmodule

// File: tb/tb_i2s_rx_deser.sv
// Self-checking bench for i2s_rx_deser: drives I2S frames bit by bit, predicts the
// decoded pairs from slot contents, and checks handshake, overrun and framing behaviour.
`timescale 1ns/1ps
module tb_i2s_rx_deser;
   localparam int DATA_W      = 24;
   localparam int SLOT_MAX    = 32;
   localparam int SYNC_STAGES = 2;

   logic i2s_clk = 1'b0;
   logic reset_n = 1'b0;
   logic sck_in  = 1'b0;
   logic ws_in   = 1'b0;
   logic sd_in   = 1'b0;

   i2s_rx_deser_if #(.DATA_W(DATA_W)) bus ();
`ifdef I2S_RX_OVR_CNT_EN
   logic [7:0] ovr_cnt;
`endif

   i2s_rx_deser #(.DATA_W(DATA_W), .SLOT_MAX(SLOT_MAX), .SYNC_STAGES(SYNC_STAGES)) dut (
      .i2s_clk (i2s_clk),
      .reset_n (reset_n),
      .sck_in  (sck_in),
      .ws_in   (ws_in),
      .sd_in   (sd_in),
      .bus     (bus)
`ifdef I2S_RX_OVR_CNT_EN
      ,
      .ovr_cnt (ovr_cnt)
`endif
   );

   always #5 i2s_clk = ~i2s_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_rise_cyc = 0;

   always @(posedge i2s_clk) cyc <= cyc + 1;

   // Observation side: accepted pairs, pulse counts, hold stability
   logic [2*DATA_W-1:0] got_q [$];
   logic [2*DATA_W-1:0] exp_q [$];
   int   valid_cycles = 0;
   int   valid_rise_cyc = 0;
   int   ovr_pulses = 0;
   int   fe_pulses = 0;
   int   fe_cyc = 0;
   int   unstable = 0;
   logic valid_prev = 1'b0;
   logic hold_prev = 1'b0;
   logic [2*DATA_W-1:0] lr_prev = '0;

   always @(negedge i2s_clk) begin
      if (reset_n) begin
         if (bus.sample_valid && bus.sample_ready) got_q.push_back({bus.sample_l, bus.sample_r});
         if (bus.sample_valid) valid_cycles <= valid_cycles + 1;
         if (bus.sample_valid && !valid_prev) valid_rise_cyc <= cyc;
         if (hold_prev && {bus.sample_l, bus.sample_r} != lr_prev) unstable <= unstable + 1;
         if (bus.overrun) ovr_pulses <= ovr_pulses + 1;
         if (bus.frame_err) begin
            fe_pulses <= fe_pulses + 1;
            fe_cyc    <= cyc;
         end
         valid_prev <= bus.sample_valid;
         hold_prev  <= bus.sample_valid && !bus.sample_ready;
         lr_prev    <= {bus.sample_l, bus.sample_r};
      end else begin
         valid_prev <= 1'b0;
         hold_prev  <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference: first DATA_W slot bits MSB-first, zero-padded when the slot is shorter
   function automatic logic [DATA_W-1:0] slot_to_sample(input logic [31:0] word, input int s);
      if (s >= DATA_W) return DATA_W'(word >> (s - DATA_W));
      else             return DATA_W'(word << (DATA_W - s));
   endfunction

   function automatic logic [31:0] rand_slot(input int s);
      logic [31:0] w;
      w = $urandom;
      if (s < 32) w = w & ((32'd1 << s) - 32'd1);
      return w;
   endfunction

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge i2s_clk);
   endtask

   // One bit period: data/ws change with SCK low, SCK rises one cycle later
   task automatic send_bit(input logic ws, input logic sd);
      @(negedge i2s_clk);
      ws_in  = ws;
      sd_in  = sd;
      sck_in = 1'b0;
      @(negedge i2s_clk);
      sck_in = 1'b1;
      last_rise_cyc = cyc;
   endtask

   // WS leads data by one bit: it flips on the LSB of each word
   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int s, input bit expect_pair);
      for (int i = 0; i < s; i++) send_bit(i == s - 1, lw[s-1-i]);
      for (int i = 0; i < s; i++) send_bit(i != s - 1, rw[s-1-i]);
      if (expect_pair) exp_q.push_back({slot_to_sample(lw, s), slot_to_sample(rw, s)});
   endtask

   task automatic set_ready(input logic v);
      @(posedge i2s_clk);
      #1 bus.sample_ready = v;
   endtask

   task automatic compare_pairs(input string tag);
      int n;
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_pair%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int v0, p0, lr;
      logic [31:0] lw, rw;
      bus.sample_ready = 1'b1;

      // Reset state
      wait_cycles(4);
      check("rst_valid", 64'(bus.sample_valid), 64'd0);
      check("rst_l", 64'(bus.sample_l), 64'd0);
      check("rst_r", 64'(bus.sample_r), 64'd0);
      check("rst_overrun", 64'(bus.overrun), 64'd0);
      check("rst_frame_err", 64'(bus.frame_err), 64'd0);
`ifdef I2S_RX_OVR_CNT_EN
      check("rst_ovr_cnt", 64'(ovr_cnt), 64'd0);
`endif
      @(negedge i2s_clk);
      reset_n = 1'b1;

      // 1: 32-bit slots, first frame only synchronises
      v0 = valid_cycles;
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b0);
      lw = {24'hA5A5A5, 8'($urandom)};
      rw = {24'h5A5A5A, 8'($urandom)};
      send_frame(lw, rw, 32, 1'b1);
      lr = last_rise_cyc;
      wait_cycles(6);
      check("t1_latency", 64'(valid_rise_cyc - lr), 64'(SYNC_STAGES + 1));
      for (int f = 0; f < 5; f++) send_frame(rand_slot(32), rand_slot(32), 32, 1'b1);
      wait_cycles(6);
      check("t1_valid_cycles", 64'(valid_cycles - v0), 64'd6);
      compare_pairs("t1");

      // 2: consumer stalls over two completions
      p0 = ovr_pulses;
      set_ready(1'b0);
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b1);
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b0);
      wait_cycles(6);
      check("t2_held_stable", 64'(unstable), 64'd0);
      check("t2_overrun_pulses", 64'(ovr_pulses - p0), 64'd1);
      check("t2_still_valid", 64'(bus.sample_valid), 64'd1);
      set_ready(1'b1);
      wait_cycles(4);
      compare_pairs("t2");
`ifdef I2S_RX_OVR_CNT_EN
      check("t2_ovr_cnt", 64'(ovr_cnt), 64'd1);
`endif

      // 3: 16-bit slots zero-padded into 24-bit samples
      send_frame(32'h1234, 32'hBEEF, 16, 1'b1);
      for (int f = 0; f < 3; f++) send_frame(rand_slot(16), rand_slot(16), 16, 1'b1);
      wait_cycles(6);
      compare_pairs("t3");

      // 4: ws stuck low -> framing error on bit SLOT_MAX+1, then resync
      p0 = fe_pulses;
      for (int i = 0; i < 40; i++) begin
         send_bit(1'b0, 1'($urandom));
         if (i == SLOT_MAX) lr = last_rise_cyc;
      end
      wait_cycles(4);
      check("t4_frame_err_pulses", 64'(fe_pulses - p0), 64'd1);
      check("t4_frame_err_latency", 64'(fe_cyc - lr), 64'(SYNC_STAGES + 1));
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b0);
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b1);
      wait_cycles(6);
      compare_pairs("t4");

      // 5: reset mid right word clears outputs at once
      lw = rand_slot(32);
      for (int i = 0; i < 32; i++) send_bit(i == 31, lw[31-i]);
      for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom));
      #2 reset_n = 1'b0;
      sck_in = 1'b0;
      ws_in  = 1'b0;
      #1;
      check("t5_valid_async", 64'(bus.sample_valid), 64'd0);
      check("t5_l_async", 64'(bus.sample_l), 64'd0);
      check("t5_r_async", 64'(bus.sample_r), 64'd0);
      wait_cycles(3);
      reset_n = 1'b1;
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b0);
      send_frame(rand_slot(32), rand_slot(32), 32, 1'b1);
      wait_cycles(6);
      compare_pairs("t5");

`ifdef I2S_RX_OVR_CNT_EN
      // 6: long stall saturates the overrun counter
      set_ready(1'b0);
      send_frame(rand_slot(16), rand_slot(16), 16, 1'b1);
      for (int f = 0; f < 299; f++) send_frame(rand_slot(16), rand_slot(16), 16, 1'b0);
      wait_cycles(6);
      check("t6_ovr_cnt_sat", 64'(ovr_cnt), 64'd255);
      set_ready(1'b1);
      wait_cycles(4);
      compare_pairs("t6");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
